// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and command sequencer in front of a single-port data memory.
// Optional address range check is enabled by defining DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_q,
  output logic              err
);

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  // last_gnt holds the index of the most recently granted port
  logic              last_gnt;
  logic              xfer_c;
  logic              sel_c;
  logic              xfer_we_c;
  logic [ADDR_W-1:0] xfer_addr_c;
  logic [DATA_W-1:0] xfer_wdata_c;
  logic              oob_c;

  logic              cmd_valid;
  logic              cmd_oob;
  logic              cmd_we;
  logic              cmd_port;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_fire_c;
  logic [DATA_W-1:0] rsp_data_c;

  // Round-robin grant; a tie goes to the port that did not win last
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        gnt0 = last_gnt;
        gnt1 = ~last_gnt;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    xfer_c       = (req0 & gnt0) | (req1 & gnt1);
    sel_c        = gnt1;
    xfer_we_c    = sel_c ? we1    : we0;
    xfer_addr_c  = sel_c ? addr1  : addr0;
    xfer_wdata_c = sel_c ? wdata1 : wdata0;
    oob_c        = RANGE_CHECK && (xfer_addr_c >= ADDR_W'(MEM_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (xfer_c) begin
      last_gnt <= sel_c;
    end
  end

  // Command stage: one accepted access per cycle, out-of-range accesses carry no enables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_oob   <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_port  <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      cmd_valid <= xfer_c & ~oob_c;
      cmd_oob   <= xfer_c & oob_c;
      if (xfer_c) begin
        cmd_we    <= xfer_we_c;
        cmd_port  <= sel_c;
        cmd_addr  <= xfer_addr_c;
        cmd_wdata <= xfer_wdata_c;
      end
    end
  end

  always_comb begin
    mem_addr    = cmd_valid ? cmd_addr  : '0;
    mem_data    = cmd_valid ? cmd_wdata : '0;
    mem_wr_en   = cmd_valid & cmd_we;
    mem_read_en = cmd_valid & ~cmd_we;
  end

  always_comb begin
    rsp_fire_c = (cmd_valid | cmd_oob) & ~cmd_we;
    rsp_data_c = cmd_valid ? mem_q : '0;
  end

  // Response stage: read data returned to the port that issued the command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (rsp_fire_c) begin
        if (cmd_port) begin
          rvalid1 <= 1'b1;
          rdata1  <= rsp_data_c;
        end else begin
          rvalid0 <= 1'b1;
          rdata0  <= rsp_data_c;
        end
      end
    end
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= cmd_oob;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
